// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage arithmetic unit.
// Combinational ALU (AND/OR/NOR/ADD/SUB/SLT/SLTU) plus an iterative unsigned
// multiply/divide unit that updates HI/LO after WIDTH cycles.
module alu_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             ovf,
   input  logic             md_start,
   input  logic             md_div,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned AW = 2 * WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SLTU = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   // ---------------------------------------------------------------- ALU
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             sum_ovf;

   // Shared adder: SUB and SLT both use a + ~b + 1
   always_comb begin
      sub     = (alu_op == OP_SUB) || (alu_op == OP_SLT);
      b_eff   = b ^ {WIDTH{sub}};
      sum     = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
      sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

   // Result select; SLT corrects the sign bit with the overflow flag
   always_comb begin
      alu_out = '0;
      ovf     = 1'b0;
      case (alu_op)
         OP_AND:  alu_out = a & b;
         OP_OR:   alu_out = a | b;
         OP_NOR:  alu_out = ~(a | b);
         OP_ADD,
         OP_SUB: begin
            alu_out = sum;
            ovf     = sum_ovf;
         end
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
         OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_out = '0;
      endcase
   end

   assign zero = (alu_out == '0);

   // ---------------------------------------------------------------- MDU
   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   mul_sum;
   logic [AW-1:0]    mul_next;
   logic [WIDTH:0]   rem_sh;
   logic             div_ok;
   logic [WIDTH-1:0] rem_sub;
   logic [AW-1:0]    div_next;
   logic [AW-1:0]    acc_step;

   // One iteration of shift-add multiply / restoring divide.
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = acc_q[AW-1:WIDTH-1];
      div_ok   = (rem_sh >= {1'b0, opb_q});
      rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
      div_next = div_ok ? {rem_sub,            acc_q[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
      acc_step = div_q ? div_next : mul_next;
   end

   // Next-state: IDLE accepts an operation, RUN iterates WIDTH times
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      div_d   = div_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md_start) begin
               acc_d   = {{WIDTH{1'b0}}, a};
               opb_d   = b;
               div_d   = md_div;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               hi_d    = acc_step[AW-1:WIDTH];
               lo_d    = acc_step[WIDTH-1:0];
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         div_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the pipeline CPU. Single-cycle combinational ALU (AND/OR/NOR/ADD/SUB/SLT/SLTU) over WIDTH-bit operands, plus an iterative unsigned multiply/divide unit that writes HI/LO registers over WIDTH cycles. Busy drives the hazard unit's stall for any instruction needing HI/LO. Replaces the per-bit ALU slice chain; the ALU path is generalised, the MDU is new sequential behaviour.

## Interface
- WIDTH, 32, operand/result width (≥4).
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt/imm).
- alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 SLTU, 100 NOR, 101 reserved.
- alu_out  out  WIDTH  combinational ALU result.
- zero  out  1  alu_out == 0.
- ovf  out  1  signed overflow for ADD/SUB; 0 for other ops.
- md_start  in  1  request MDU operation; accepted only when busy==0.
- md_div  in  1  sampled with md_start: 0 MULTU, 1 DIVU.
- busy  out  1  MDU operation in progress.
- done  out  1  one-cycle pulse when HI/LO update.
- hi  out  WIDTH  MULTU upper product / DIVU remainder.
- lo  out  WIDTH  MULTU lower product / DIVU quotient.

## Operation
- ALU: purely combinational, independent of MDU state.
  - ADD/SUB: a + (b ^ {WIDTH{sub}}) + sub, result truncated to WIDTH; carry-out discarded.
  - ovf = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), b' = effective B.
  - SLT: alu_out = {0…, sub_sum[W-1] ^ sub_ovf} (correct across overflow: a=0x8000_0000, b=1 → 1).
  - SLTU: alu_out = {0…, a < b unsigned}.
  - Reserved op: alu_out = 0.
- MDU states: IDLE, RUN.
  - IDLE: md_start=1 → latch a, b, md_div into internal registers; count=0; go to RUN.
  - RUN: one iteration per cycle.
    - MULTU: shift-add radix-2 over a 2·WIDTH accumulator.
    - DIVU: restoring; shift remainder left, subtract divisor, set quotient bit if non-negative.
  - After WIDTH iterations: load hi/lo, pulse done, return to IDLE.
- Operands are latched at acceptance; later a/b/md_div changes have no effect.
- md_start while busy=1 is ignored; no queueing.
- hi/lo hold previous values throughout RUN; they change only on the done cycle.
- DIVU by zero is not special-cased: natural restoring result, lo = all ones, hi = dividend.
- MULTU result is the full 2·WIDTH product {hi, lo}; no overflow.

## Timing
- Reset (rst high at an edge): busy=0, done=0, hi=0, lo=0, state IDLE, counter 0.
  - Dominates md_start in the same cycle.
  - Aborts any RUN in progress; no done pulse.
- Acceptance edge E0: busy=1 from the cycle after E0.
- Iterations at edges E1…E(WIDTH). At E(WIDTH): hi/lo updated, busy→0, done=1 for exactly one cycle.
- Latency: WIDTH cycles from the acceptance edge to visible result. Throughput: one op per WIDTH+1 cycles when back-to-back.
- Back-to-back: md_start during the done cycle (busy=0) is accepted at that edge.
- ALU outputs have zero latency and are valid in the same cycle as a/b/alu_op.

## Test plan
- ALU sweep, WIDTH=32: a=0x7FFF_FFFF, b=1, ADD → alu_out=0x8000_0000, ovf=1. SUB a=b=5 → 0, zero=1. SLT a=0x8000_0000, b=1 → 1. SLTU same → 0. NOR 0,0 → 0xFFFF_FFFF.
- MULTU: a=0xFFFF_FFFF, b=0xFFFF_FFFF → after 32 cycles hi=0xFFFF_FFFE, lo=0x0000_0001; done high for one cycle; busy high for exactly 32 cycles.
- DIVU: a=100, b=7 → lo=14, hi=2. Divide by zero, a=0x1234 → lo=0xFFFF_FFFF, hi=0x1234.
- Operand/start isolation: change a, b and pulse md_start mid-RUN → result matches the original operands; no second op starts.
- Reset mid-op: rst at cycle 10 of a MULTU → busy=0, hi=lo=0, no done pulse. A new DIVU then completes normally.
- WIDTH=8 build: MULTU 200×200 → {hi,lo}=0x9C40 after 8 cycles. Back-to-back start in the done cycle → accepted immediately.
